product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 4, giving the number of products summed per group (legal 1..15).
REQ-002 The block SHALL have parameter ACC_W, default 12, giving the accumulator width (legal 8..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port p_in, input, 8 bits: unsigned product from the upstream 4x4 multiplier.
REQ-006 The block SHALL have port p_valid, input, 1 bit: p_in is valid.
REQ-007 The block SHALL have port p_ready, output, 1 bit: the block can accept p_in this cycle.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous abort of the current group.
REQ-009 The block SHALL have port acc_out, output, ACC_W bits: the running or final sum.
REQ-010 The block SHALL have port acc_valid, output, 1 bit: acc_out holds a completed group sum.
REQ-011 The block SHALL have port acc_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port count, output, 4 bits: products accepted in the current group.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky carry-out of the current group.

Function
REQ-014 An accept SHALL occur on a rising edge with p_valid=1 and p_ready=1; no other condition changes acc_out or count, except clear.
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-016 p_ready SHALL equal (state != HOLD) AND (clear = 0), combinationally.
REQ-017 IDLE: on accept, acc_out <= zero-extended p_in, count <= 1 and ovf <= 0; next state is HOLD if N_TERMS = 1, otherwise ACCUM.
REQ-018 ACCUM: on accept, acc_out <= (acc_out + p_in) mod 2^ACC_W and count <= count + 1; ovf <= 1 if the addition carries out of ACC_W bits.
REQ-019 ACCUM: the accept that makes count equal N_TERMS SHALL move the FSM to HOLD.
REQ-020 ACCUM with p_valid=0 SHALL hold all state; gaps of any length are legal.
REQ-021 HOLD: acc_valid = 1; acc_out, count and ovf are stable; p_ready = 0.
REQ-022 HOLD: on acc_ready = 1, the FSM SHALL move to IDLE, and acc_out <= 0, count <= 0 and ovf <= 0 on the same edge.
REQ-023 acc_valid SHALL be 1 in HOLD only and SHALL be driven from registered state.
REQ-024 Latency: acc_valid SHALL rise on the edge that performs the N_TERMS-th accept (visible the following cycle).
REQ-025 Minimum group period SHALL be N_TERMS + 1 cycles with continuous p_valid and acc_ready.
REQ-026 clear = 1 at an edge, in any state, SHALL force IDLE with acc_out = 0, count = 0 and ovf = 0; it overrides accept and acc_ready in the same cycle.
REQ-027 In IDLE and ACCUM, acc_out SHALL show the running sum; it is informational only while acc_valid = 0.

Reset
REQ-028 rst_n = 0 SHALL immediately, without a clock, force IDLE with acc_out = 0, count = 0, ovf = 0 and acc_valid = 0.
REQ-029 While rst_n = 0, p_ready SHALL be 0.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.
REQ-031 Reset asserted mid-group or in HOLD SHALL discard the partial or pending result with no acc_valid pulse.

Verification
REQ-032 Scenario: defaults, p_in = 120, 18, 156, 30 on consecutive cycles, acc_ready = 1 -> acc_valid = 1 for 1 cycle, acc_out = 324 (0x144), count = 4, ovf = 0, then IDLE.
REQ-033 Scenario: same group with acc_ready = 0 for 3 cycles in HOLD -> acc_out stays 324 and p_ready stays 0 for all 3 cycles; release on acc_ready = 1.
REQ-034 Scenario: p_valid gaps of 0, 2 and 5 cycles between the 4 products 225, 225, 225, 225 -> acc_out = 900, ovf = 0; completion timing follows the last accept only.
REQ-035 Scenario: ACC_W = 8, N_TERMS = 2, p_in = 200 then 100 -> acc_out = 44, ovf = 1; the next group starts with ovf = 0.
REQ-036 Scenario: clear asserted after 2 accepts, with p_valid = 1 on the clear cycle -> p_ready = 0 that cycle, acc_out = 0, count = 0; the next 4 products form a fresh group.
REQ-037 Scenario: rst_n pulsed low mid-cycle after 3 accepts -> outputs zero asynchronously, no acc_valid pulse; after release, a full group 1, 2, 3, 4 gives acc_out = 10.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle for product_accumulator: product input stream,
// group-abort control and the completed-sum output stream.
interface product_accumulator_if #(
  parameter int ACC_W = 12
);
  // Upstream product stream
  logic [7:0]       p_in;
  logic             p_valid;
  logic             p_ready;
  // Group abort
  logic             clear;
  // Downstream result stream
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  // Group status
  logic [3:0]       count;
  logic             ovf;

  // Accumulator side
  modport slave (
    input  p_in,
    input  p_valid,
    output p_ready,
    input  clear,
    output acc_out,
    output acc_valid,
    input  acc_ready,
    output count,
    output ovf
  );

  // Producer / consumer side
  modport master (
    output p_in,
    output p_valid,
    input  p_ready,
    output clear,
    input  acc_out,
    input  acc_valid,
    output acc_ready,
    input  count,
    input  ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums N_TERMS unsigned 8-bit products into an
// ACC_W-bit accumulator, then holds the group sum until downstream takes it.
// A sticky overflow flag records any carry out of ACC_W bits within a group.
module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(N_TERMS);
  localparam bit         SINGLE   = (N_TERMS == 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [3:0]         count_q, count_d;
  logic               ovf_q,   ovf_d;
  logic               acc_valid_q, acc_valid_d;

  logic               ready_s;
  logic               accept_s;
  logic [ACC_W-1:0]   p_ext_s;
  logic [ACC_W:0]     sum_s;
  logic [3:0]         count_inc_s;

  // Ready is withheld while holding a result, while clear aborts the group,
  // and while reset is asserted (state alone would already read IDLE then).
  assign ready_s     = rst_n & ~bus.clear & (state_q != ST_HOLD);
  assign accept_s    = bus.p_valid & ready_s;
  assign p_ext_s     = ACC_W'(bus.p_in);
  assign sum_s       = {1'b0, acc_q} + {1'b0, p_ext_s};
  assign count_inc_s = count_q + 4'd1;

  // Next-state and datapath update; clear has priority over everything.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      count_d = 4'd0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            acc_d   = p_ext_s;
            count_d = 4'd1;
            ovf_d   = 1'b0;
            state_d = SINGLE ? ST_HOLD : ST_ACCUM;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_d   = sum_s[ACC_W-1:0];
            count_d = count_inc_s;
            ovf_d   = ovf_q | sum_s[ACC_W];
            if (count_inc_s == LAST_CNT) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (bus.acc_ready) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            count_d = 4'd0;
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
          count_d = 4'd0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // Result-valid flag tracks entry into HOLD so it is a clean register output.
  always_comb begin
    acc_valid_d = 1'b0;
    if (state_d == ST_HOLD) begin
      acc_valid_d = 1'b1;
    end else begin
      acc_valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= 4'd0;
      ovf_q       <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign bus.p_ready   = ready_s;
  assign bus.acc_out   = acc_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator. Expected group
// results are queued when a group's stimulus is issued and popped when the
// DUT presents acc_valid. A second instance covers the narrow/short config.
module tb_product_accumulator;

  typedef struct {
    logic [31:0] acc;
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb_a[$];
  exp_t sb_b[$];

  product_accumulator_if #(.ACC_W(12)) ifa ();
  product_accumulator_if #(.ACC_W(8))  ifb ();

  product_accumulator #(.N_TERMS(4), .ACC_W(12)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  product_accumulator #(.N_TERMS(2), .ACC_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] p);
    ifa.p_valid = 1'b1;
    ifa.p_in    = p;
    tick();
    ifa.p_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p);
    ifb.p_valid = 1'b1;
    ifb.p_in    = p;
    tick();
    ifb.p_valid = 1'b0;
  endtask

  task automatic push_a(input int acc, input int cnt, input logic ovf);
    exp_t e;
    e.acc = 32'(acc);
    e.cnt = 32'(cnt);
    e.ovf = ovf;
    sb_a.push_back(e);
  endtask

  task automatic push_b(input int acc, input int cnt, input logic ovf);
    exp_t e;
    e.acc = 32'(acc);
    e.cnt = 32'(cnt);
    e.ovf = ovf;
    sb_b.push_back(e);
  endtask

  task automatic result_a(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 32'(ifa.acc_valid), 32'd1);
    n_cmp++;
    assert (sb_a.size() > 0) else begin
      n_err++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      chk({tag, "_acc"}, 32'(ifa.acc_out), e.acc);
      chk({tag, "_cnt"}, 32'(ifa.count), e.cnt);
      chk({tag, "_ovf"}, 32'(ifa.ovf), 32'(e.ovf));
    end
  endtask

  task automatic result_b(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 32'(ifb.acc_valid), 32'd1);
    n_cmp++;
    assert (sb_b.size() > 0) else begin
      n_err++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb_b.size() > 0) begin
      e = sb_b.pop_front();
      chk({tag, "_acc"}, 32'(ifb.acc_out), e.acc);
      chk({tag, "_cnt"}, 32'(ifb.count), e.cnt);
      chk({tag, "_ovf"}, 32'(ifb.ovf), 32'(e.ovf));
    end
  endtask

  task automatic idle_a(input string tag);
    chk({tag, "_valid"}, 32'(ifa.acc_valid), 32'd0);
    chk({tag, "_acc"}, 32'(ifa.acc_out), 32'd0);
    chk({tag, "_cnt"}, 32'(ifa.count), 32'd0);
    chk({tag, "_ovf"}, 32'(ifa.ovf), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifa.p_in = 8'd0; ifa.p_valid = 1'b0; ifa.clear = 1'b0; ifa.acc_ready = 1'b1;
    ifb.p_in = 8'd0; ifb.p_valid = 1'b0; ifb.clear = 1'b0; ifb.acc_ready = 1'b1;

    // Reset state
    #12;
    idle_a("rst");
    chk("rst_ready", 32'(ifa.p_ready), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(ifa.p_ready), 32'd1);
    @(negedge clk);

    // Basic group, acc_ready high: one-cycle valid, then IDLE
    push_a(324, 4, 1'b0);
    send_a(8'd120);
    chk("g1_acc1", 32'(ifa.acc_out), 32'd120);
    chk("g1_cnt1", 32'(ifa.count), 32'd1);
    send_a(8'd18);
    send_a(8'd156);
    chk("g1_acc3", 32'(ifa.acc_out), 32'd294);
    chk("g1_valid3", 32'(ifa.acc_valid), 32'd0);
    send_a(8'd30);
    result_a("g1");
    chk("g1_hold_ready", 32'(ifa.p_ready), 32'd0);
    tick();
    idle_a("g1_after");

    // Same group, result held off for 3 cycles
    ifa.acc_ready = 1'b0;
    push_a(324, 4, 1'b0);
    send_a(8'd120);
    send_a(8'd18);
    send_a(8'd156);
    send_a(8'd30);
    result_a("g2");
    for (int i = 0; i < 3; i++) begin
      ifa.p_valid = 1'b1;
      ifa.p_in    = 8'd7;
      #1;
      chk("g2_hold_ready", 32'(ifa.p_ready), 32'd0);
      chk("g2_hold_acc", 32'(ifa.acc_out), 32'd324);
      chk("g2_hold_valid", 32'(ifa.acc_valid), 32'd1);
      tick();
    end
    ifa.p_valid = 1'b0;
    chk("g2_still_acc", 32'(ifa.acc_out), 32'd324);
    chk("g2_still_cnt", 32'(ifa.count), 32'd4);
    ifa.acc_ready = 1'b1;
    tick();
    idle_a("g2_after");

    // Gaps of 0, 2 and 5 cycles between products
    push_a(900, 4, 1'b0);
    send_a(8'd225);
    send_a(8'd225);
    tick();
    tick();
    chk("g3_gap_cnt", 32'(ifa.count), 32'd2);
    chk("g3_gap_acc", 32'(ifa.acc_out), 32'd450);
    send_a(8'd225);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("g3_gap_valid", 32'(ifa.acc_valid), 32'd0);
    end
    chk("g3_gap_cnt3", 32'(ifa.count), 32'd3);
    send_a(8'd225);
    result_a("g3");
    tick();
    idle_a("g3_after");

    // Narrow accumulator: overflow is sticky within the group only
    push_b(44, 2, 1'b1);
    send_b(8'd200);
    chk("b1_ovf1", 32'(ifb.ovf), 32'd0);
    send_b(8'd100);
    result_b("b1");
    tick();
    chk("b1_after_ovf", 32'(ifb.ovf), 32'd0);
    push_b(30, 2, 1'b0);
    send_b(8'd10);
    chk("b2_ovf1", 32'(ifb.ovf), 32'd0);
    send_b(8'd20);
    result_b("b2");
    tick();

    // Clear after two accepts, with p_valid on the clear cycle
    send_a(8'd1);
    send_a(8'd2);
    chk("clr_pre_acc", 32'(ifa.acc_out), 32'd3);
    ifa.clear   = 1'b1;
    ifa.p_valid = 1'b1;
    ifa.p_in    = 8'd9;
    #1;
    chk("clr_ready", 32'(ifa.p_ready), 32'd0);
    tick();
    ifa.clear   = 1'b0;
    ifa.p_valid = 1'b0;
    idle_a("clr_after");
    push_a(18, 4, 1'b0);
    send_a(8'd3);
    chk("clr_fresh_cnt", 32'(ifa.count), 32'd1);
    send_a(8'd4);
    send_a(8'd5);
    send_a(8'd6);
    result_a("g4");
    tick();

    // Asynchronous reset mid-group discards the partial sum
    send_a(8'd1);
    send_a(8'd2);
    send_a(8'd3);
    chk("rst_mid_cnt", 32'(ifa.count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    idle_a("rst_mid");
    chk("rst_mid_ready", 32'(ifa.p_ready), 32'd0);
    #3 rst_n = 1'b1;
    push_a(10, 4, 1'b0);
    ifa.p_valid = 1'b1;
    ifa.p_in    = 8'd1;
    tick();
    ifa.p_valid = 1'b0;
    chk("rst_first_cnt", 32'(ifa.count), 32'd1);
    chk("rst_first_valid", 32'(ifa.acc_valid), 32'd0);
    send_a(8'd2);
    send_a(8'd3);
    send_a(8'd4);
    result_a("g5");
    tick();
    idle_a("g5_after");

    chk("sb_a_empty", 32'(sb_a.size()), 32'd0);
    chk("sb_b_empty", 32'(sb_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
